// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
// Groups the control inputs and measurement outputs of pwm_capture.
//   en          capture enable (master -> slave)
//   pwm_in      external PWM, asynchronous to clk (master -> slave)
//   clk_div     prescaler exponent, one tick every 2^clk_div clocks
//   ovf_clr     clears the sticky overflow flag
//   high_time   ticks the input was high in the last complete period
//   period      ticks between the last two rising edges
//   meas_valid  one-cycle pulse when high_time/period update
//   overflow    sticky flag, period counter saturated
// ---------------------------------------------------------------------------
interface pwm_capture_if #(
  parameter int CNT_W = 16
) ();

  logic             en;
  logic             pwm_in;
  logic [3:0]       clk_div;
  logic             ovf_clr;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             overflow;

  modport master (
    output en, pwm_in, clk_div, ovf_clr,
    input  high_time, period, meas_valid, overflow
  );

  modport slave (
    input  en, pwm_in, clk_div, ovf_clr,
    output high_time, period, meas_valid, overflow
  );

endinterface

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
// Measures the high time and the period of an asynchronous PWM input in
// prescaled clock ticks. Measurements are taken between consecutive rising
// edges; the first rising edge after idle only arms the capture.
//
// Ports
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    pwm_capture_if.slave (en, pwm_in, clk_div, ovf_clr in;
//          high_time, period, meas_valid, overflow out)
//
// Parameters
//   CNT_W        width of the tick counters and measurement outputs
//   SYNC_STAGES  number of pwm_in synchronizer flops (minimum 2)
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // input conditioning
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;
  logic                   sync_s;
  logic                   rise_s;
  logic                   fall_s;

  // prescaler
  logic [14:0]            presc_r;
  logic [14:0]            presc_limit_s;
  logic                   tick_s;

  // measurement FSM
  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       hi_cnt_r;
  logic [CNT_W-1:0]       hi_cnt_s;
  logic [CNT_W-1:0]       per_cnt_r;
  logic [CNT_W-1:0]       per_cnt_s;

  // outputs
  logic [CNT_W-1:0]       high_time_r;
  logic [CNT_W-1:0]       high_time_s;
  logic [CNT_W-1:0]       period_r;
  logic [CNT_W-1:0]       period_s;
  logic                   meas_valid_r;
  logic                   meas_set_s;
  logic                   overflow_r;
  logic                   ovf_set_s;

  // Synchronize pwm_in and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      dly_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.pwm_in};
      dly_r  <= sync_s;
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign rise_s = sync_s & ~dly_r;
  assign fall_s = ~sync_s & dly_r;

  // Terminal count is 2^clk_div-1; the 16-bit intermediate keeps
  // clk_div=15 from wrapping to zero before the subtraction.
  assign presc_limit_s = 15'((16'd1 << bus.clk_div) - 16'd1);

  // A ">=" compare lets a lowered clk_div take effect at the next compare
  // instead of letting the prescaler run all the way round to zero.
  assign tick_s = (presc_r >= presc_limit_s);

  // Prescaler: restarts on every rise so each period begins at phase zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= 15'd0;
    end else if (!bus.en || rise_s || tick_s) begin
      presc_r <= 15'd0;
    end else begin
      presc_r <= presc_r + 15'd1;
    end
  end

  // FSM state and tick counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      hi_cnt_r  <= CNT_ZERO;
      per_cnt_r <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      hi_cnt_r  <= hi_cnt_s;
      per_cnt_r <= per_cnt_s;
    end
  end

  // Next-state, counter and measurement-latch logic.
  always_comb begin
    state_s     = state_r;
    hi_cnt_s    = hi_cnt_r;
    per_cnt_s   = per_cnt_r;
    high_time_s = high_time_r;
    period_s    = period_r;
    meas_set_s  = 1'b0;
    ovf_set_s   = 1'b0;

    if (!bus.en) begin
      state_s   = IDLE;
      hi_cnt_s  = CNT_ZERO;
      per_cnt_s = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          // Only a rising edge arms the capture; falls are ignored here.
          if (rise_s) begin
            state_s   = HIGH;
            hi_cnt_s  = CNT_ZERO;
            per_cnt_s = CNT_ZERO;
          end else begin
            state_s   = IDLE;
          end
        end

        HIGH: begin
          if (tick_s && (per_cnt_r == CNT_MAX)) begin
            ovf_set_s = 1'b1;
            state_s   = IDLE;
            hi_cnt_s  = CNT_ZERO;
            per_cnt_s = CNT_ZERO;
          end else begin
            // The tick in the fall cycle still belongs to the high phase.
            if (tick_s) begin
              hi_cnt_s  = hi_cnt_r + CNT_ONE;
              per_cnt_s = per_cnt_r + CNT_ONE;
            end else begin
              hi_cnt_s  = hi_cnt_r;
            end
            if (fall_s) begin
              state_s = LOW;
            end else begin
              state_s = HIGH;
            end
          end
        end

        LOW: begin
          // A tick at full scale means the period no longer fits, even if
          // a rise arrives in the same cycle; report overflow instead.
          if (tick_s && (per_cnt_r == CNT_MAX)) begin
            ovf_set_s = 1'b1;
            state_s   = IDLE;
            hi_cnt_s  = CNT_ZERO;
            per_cnt_s = CNT_ZERO;
          end else if (rise_s) begin
            // A tick coinciding with the rise closes the old period; it is
            // not carried into the new one (counters restart at zero).
            meas_set_s  = 1'b1;
            high_time_s = hi_cnt_r;
            period_s    = per_cnt_r + {{(CNT_W-1){1'b0}}, tick_s};
            state_s     = HIGH;
            hi_cnt_s    = CNT_ZERO;
            per_cnt_s   = CNT_ZERO;
          end else if (tick_s) begin
            per_cnt_s = per_cnt_r + CNT_ONE;
          end else begin
            per_cnt_s = per_cnt_r;
          end
        end

        default: begin
          state_s   = IDLE;
          hi_cnt_s  = CNT_ZERO;
          per_cnt_s = CNT_ZERO;
        end
      endcase
    end
  end

  // Registered measurement outputs and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_time_r  <= CNT_ZERO;
      period_r     <= CNT_ZERO;
      meas_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      high_time_r  <= high_time_s;
      period_r     <= period_s;
      meas_valid_r <= meas_set_s;
      // A new overflow beats a simultaneous clear.
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign bus.high_time  = high_time_r;
  assign bus.period     = period_r;
  assign bus.meas_valid = meas_valid_r;
  assign bus.overflow   = overflow_r;

endmodule
